// File: rtl/lcd_pkg.sv
// Shared types and helpers for the 8080-style LCD parallel writer.
// Optional build macro: LCD_CS_GATE_EN (gates lcd_cs around writes).
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } lcd_state_e;

    // A command word with this value produces no WR strobe: a timed delay.
    localparam int unsigned LCD_NOP = 0;

    function automatic int phase_cnt_w(input int s, input int t, input int h);
        int m;
        m = s;
        if (t > m) m = t;
        if (h > m) m = h;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lcd_parallel_writer_if.sv
// Command stream from the frame/command sequencer into the LCD writer.
// Optional build macro: LCD_CS_GATE_EN (no effect on this interface).
interface lcd_parallel_writer_if #(
    parameter int DATA_W = 8,
    parameter int REP_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_is_cmd;
    logic [DATA_W-1:0] cmd_data;
    logic [REP_W-1:0]  cmd_repeat;
    logic              busy;

    modport master (
        output cmd_valid, cmd_is_cmd, cmd_data, cmd_repeat,
        input  cmd_ready, busy
    );

    modport slave (
        input  cmd_valid, cmd_is_cmd, cmd_data, cmd_repeat,
        output cmd_ready, busy
    );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with zero flag, shared by SETUP/STROBE/HOLD.
// Optional build macro: LCD_CS_GATE_EN (no effect here).
module lcd_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/lcd_parallel_writer.sv
// Write-only 8080-style LCD driver with programmable timing and repeat.
// Optional build macro: LCD_CS_GATE_EN (lcd_cs high while idle).
module lcd_parallel_writer
    import lcd_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int REP_W          = 16,
    parameter int SETUP_CYC      = 1,
    parameter int STROBE_CYC     = 2,
    parameter int HOLD_CYC       = 1,
    parameter bit WR_ACTIVE_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_parallel_writer_if.slave cmd,
    output logic              lcd_rs,
    output logic              lcd_cs,
    output logic              lcd_wr,
    output logic [DATA_W-1:0] lcd_d
);
    localparam int   CW     = phase_cnt_w(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam logic WR_ON  = WR_ACTIVE_HIGH;
    localparam logic WR_OFF = ~WR_ACTIVE_HIGH;

    lcd_state_e        state_q, state_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              rs_q, rs_d;
    logic              nop_q, nop_d;
    logic              wr_q, wr_d;
    logic              busy_q;
    logic              en_q;
    logic              load;
    logic [CW-1:0]     load_val;
    logic              zero;
    logic              take;
    logic              accept;
    logic              last_hold;

    lcd_phase_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .val_i  (load_val),
        .zero_o (zero)
    );

    assign last_hold = (state_q == HOLD) && zero;
    assign take      = en_q && ((state_q == IDLE) ||
                                (last_hold && rep_q == '0));
    assign accept    = take && cmd.cmd_valid;

    always_comb begin
        state_d  = state_q;
        rep_d    = rep_q;
        load     = 1'b0;
        load_val = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SETUP;
                    load     = 1'b1;
                    load_val = CW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (zero) begin
                    state_d  = STROBE;
                    load     = 1'b1;
                    load_val = CW'(STROBE_CYC - 1);
                end
            end
            STROBE: begin
                if (zero) begin
                    state_d  = HOLD;
                    load     = 1'b1;
                    load_val = CW'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (zero) begin
                    if (rep_q != '0 || accept) begin
                        state_d  = SETUP;
                        load     = 1'b1;
                        load_val = CW'(SETUP_CYC - 1);
                        if (rep_q != '0)
                            rep_d = rep_q - REP_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept)
            rep_d = cmd.cmd_repeat;
    end

    // Bus value and RS only move when a new word is accepted.
    always_comb begin
        rs_d  = rs_q;
        d_d   = d_q;
        nop_d = nop_q;
        if (accept) begin
            rs_d  = ~cmd.cmd_is_cmd;
            d_d   = cmd.cmd_data;
            nop_d = cmd.cmd_is_cmd &&
                    (cmd.cmd_data == DATA_W'(LCD_NOP));
        end
        wr_d = (state_d == STROBE && !nop_d) ? WR_ON : WR_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rep_q   <= '0;
            d_q     <= '0;
            rs_q    <= 1'b1;
            nop_q   <= 1'b0;
            wr_q    <= WR_OFF;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            d_q     <= d_d;
            rs_q    <= rs_d;
            nop_q   <= nop_d;
            wr_q    <= wr_d;
            busy_q  <= (state_d != IDLE);
            en_q    <= 1'b1;
        end
    end

`ifdef LCD_CS_GATE_EN
    logic cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cs_q <= 1'b1;
        else
            cs_q <= (state_d == IDLE);
    end

    assign lcd_cs = cs_q;
`else
    assign lcd_cs = 1'b0;
`endif

    assign cmd.cmd_ready = take;
    assign cmd.busy      = busy_q;
    assign lcd_rs        = rs_q;
    assign lcd_wr        = wr_q;
    assign lcd_d         = d_q;
endmodule

// File: tb/tb_lcd_parallel_writer.sv
// Directed bench: default 8-bit writer plus a 16-bit active-low variant.
// Optional build macro: LCD_CS_GATE_EN (changes expected lcd_cs).
module tb_lcd_parallel_writer;
    import lcd_pkg::*;

`ifdef LCD_CS_GATE_EN
    localparam logic CS_IDLE = 1'b1;
`else
    localparam logic CS_IDLE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    always #5 clk = ~clk;

    lcd_parallel_writer_if #(.DATA_W(8), .REP_W(16)) if0 ();
    lcd_parallel_writer_if #(.DATA_W(16), .REP_W(16)) if1 ();

    logic       rs0, cs0, wr0;
    logic [7:0] d0;
    logic        rs1, cs1, wr1;
    logic [15:0] d1;

    lcd_parallel_writer u_dut0 (
        .clk    (clk),
        .rst_n  (rst0_n),
        .cmd    (if0.slave),
        .lcd_rs (rs0),
        .lcd_cs (cs0),
        .lcd_wr (wr0),
        .lcd_d  (d0)
    );

    lcd_parallel_writer #(
        .DATA_W         (16),
        .REP_W          (16),
        .SETUP_CYC      (2),
        .STROBE_CYC     (3),
        .HOLD_CYC       (2),
        .WR_ACTIVE_HIGH (1'b0)
    ) u_dut1 (
        .clk    (clk),
        .rst_n  (rst1_n),
        .cmd    (if1.slave),
        .lcd_rs (rs1),
        .lcd_cs (cs1),
        .lcd_wr (wr1),
        .lcd_d  (d1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Issue one word on dut0 and profile the write until busy drops.
    task automatic run0(input logic ic, input logic [7:0] dv,
                        input logic [15:0] rp, output int nb,
                        output int nw, output int ns, output int nr);
        logic prev;
        int   k;
        @(negedge clk);
        if0.cmd_valid  = 1'b1;
        if0.cmd_is_cmd = ic;
        if0.cmd_data   = dv;
        if0.cmd_repeat = rp;
        k = 0;
        while (!if0.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 if0.cmd_valid = 1'b0;
        nb = 0; nw = 0; ns = 0; nr = 0; prev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!if0.busy) break;
            nb++;
            if (wr0) nw++;
            if (wr0 && !prev) ns++;
            if (if0.cmd_ready) nr++;
            prev = wr0;
        end
    endtask

    logic [4:0] wv, bv, rv, cv;
    logic [3:0] wv1;
    logic [7:0] words [3];
    int ts [3];
    int nb, nw, ns, nr, idx, cyc;
    logic acc, prev;

    initial begin
        if0.cmd_valid = 1'b0; if0.cmd_is_cmd = 1'b0;
        if0.cmd_data = '0; if0.cmd_repeat = '0;
        if1.cmd_valid = 1'b0; if1.cmd_is_cmd = 1'b0;
        if1.cmd_data = '0; if1.cmd_repeat = '0;

        #12;
        chk("rst_wr", wr0, 1'b0);
        chk("rst_rs", rs0, 1'b1);
        chk("rst_d", d0, 8'h00);
        chk("rst_busy", if0.busy, 1'b0);
        chk("rst_ready", if0.cmd_ready, 1'b0);
        chk("rst_cs", cs0, CS_IDLE);
        chk("rst_wr1", wr1, 1'b1);

        // Valid offered across the first edge after release must be ignored.
        @(negedge clk);
        rst0_n = 1'b1; rst1_n = 1'b1;
        if0.cmd_valid = 1'b1; if0.cmd_data = 8'h77;
        #1 chk("rdy_first_edge", if0.cmd_ready, 1'b0);
        @(posedge clk);
        #1 if0.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rdy_after", if0.cmd_ready, 1'b1);
        chk("drop_busy", if0.busy, 1'b0);
        chk("drop_d", d0, 8'h00);

        // Single data word, cycle-exact profile.
        @(negedge clk);
        if0.cmd_valid = 1'b1; if0.cmd_is_cmd = 1'b0;
        if0.cmd_data = 8'hA5; if0.cmd_repeat = '0;
        chk("t1_ready0", if0.cmd_ready, 1'b1);
        @(posedge clk);
        #1 if0.cmd_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            wv[c] = wr0; bv[c] = if0.busy;
            rv[c] = if0.cmd_ready; cv[c] = cs0;
            if (c == 0) begin
                chk("t1_rs", rs0, 1'b1);
                chk("t1_d", d0, 8'hA5);
            end
        end
        chk("t1_wr", wv, 5'b00110);
        chk("t1_busy", bv, 5'b01111);
        chk("t1_ready", rv, 5'b11000);
        chk("t1_cs", cv, CS_IDLE ? 5'b10000 : 5'b00000);
        chk("t1_d_idle", d0, 8'hA5);

        // Three words streamed with valid held high.
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        idx = 0; cyc = 0; nb = 0; ns = 0; prev = 1'b0;
        @(negedge clk);
        if0.cmd_valid = 1'b1; if0.cmd_data = words[0];
        for (int i = 0; i < 100; i++) begin
            acc = if0.cmd_valid && if0.cmd_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) if0.cmd_data = words[idx];
                else if0.cmd_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (if0.busy) nb++;
            if (wr0 && !prev && ns < 3) begin
                ts[ns] = cyc;
                chk("b2b_d", d0, words[ns]);
                ns++;
            end
            prev = wr0;
            if (idx == 3 && !if0.busy) break;
        end
        chk("b2b_busy", nb, 12);
        chk("b2b_strobes", ns, 3);
        chk("b2b_per1", ts[1] - ts[0], 4);
        chk("b2b_per2", ts[2] - ts[1], 4);

        // Command with repeat=4.
        run0(1'b1, 8'h2C, 16'd4, nb, nw, ns, nr);
        chk("rep_busy", nb, 20);
        chk("rep_wr_cyc", nw, 10);
        chk("rep_strobes", ns, 5);
        chk("rep_ready", nr, 1);
        chk("rep_rs", rs0, 1'b0);
        chk("rep_d", d0, 8'h2C);

        // NOP delay, repeat=9.
        run0(1'b1, 8'h00, 16'd9, nb, nw, ns, nr);
        chk("nop_busy", nb, 40);
        chk("nop_wr", nw, 0);
        chk("nop_ready", nr, 1);
        chk("nop_ready_end", if0.cmd_ready, 1'b1);

        // 16-bit active-low variant, reset while strobing.
        @(negedge clk);
        if1.cmd_valid = 1'b1; if1.cmd_is_cmd = 1'b0;
        if1.cmd_data = 16'h1234; if1.cmd_repeat = '0;
        chk("v1_ready", if1.cmd_ready, 1'b1);
        @(posedge clk);
        #1 if1.cmd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wv1[c] = wr1;
            if (c == 2) chk("v1_d", d1, 16'h1234);
        end
        chk("v1_wr", wv1, 4'b0011);
        rst1_n = 1'b0;
        #1;
        chk("v1_rst_wr", wr1, 1'b1);
        chk("v1_rst_d", d1, 16'h0000);
        chk("v1_rst_busy", if1.busy, 1'b0);
        chk("v1_rst_rs", rs1, 1'b1);
        @(negedge clk);
        rst1_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("v1_no_replay", if1.busy, 1'b0);
        chk("v1_d_after", d1, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
